// File: rtl/ysyx_lsu.sv
// Load/store unit: turns one EXU memory request into an AXI4-Lite-style read
// or write transaction. It returns extended load data or a store-done pulse,
// with a fault flag for misalignment, bus errors and handshake timeouts.
module ysyx_lsu #(
  parameter int BIT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic [BIT_W-1:0] lsu_addr,
  input  logic [BIT_W-1:0] lsu_wdata,
  input  logic             lsu_ren,
  input  logic             lsu_wen,
  input  logic [2:0]       lsu_func3,
  output logic [BIT_W-1:0] lsu_rdata_o,
  output logic             lsu_rvalid_o,
  output logic             lsu_wready_o,
  output logic             lsu_fault_o,
  output logic [BIT_W-1:0] araddr_o,
  output logic             arvalid_o,
  input  logic             arready,
  input  logic [BIT_W-1:0] rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready_o,
  output logic [BIT_W-1:0] awaddr_o,
  output logic             awvalid_o,
  input  logic             awready,
  output logic [BIT_W-1:0] wdata_o,
  output logic [3:0]       wstrb_o,
  output logic             wvalid_o,
  input  logic             wready,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic            is_load_q;

  logic            misal;
  logic [3:0]      st_strb;
  logic [BIT_W-1:0] st_data;
  logic [BIT_W-1:0] lane;
  logic [BIT_W-1:0] ld_ext;
  logic            aw_done;
  logic            w_done;
  logic            progress;
  logic            tmo_fire;

  // Request decode: alignment check plus store strobe/lane replication.
  always_comb begin
    misal   = 1'b0;
    st_strb = 4'b1111;
    st_data = lsu_wdata;
    case (lsu_func3)
      3'b000, 3'b100: misal = 1'b0;
      3'b001, 3'b101: misal = lsu_addr[0];
      3'b010:         misal = (lsu_addr[1:0] != 2'b00);
      default:        misal = 1'b1;
    endcase
    case (lsu_func3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << lsu_addr[1:0];
        st_data = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << lsu_addr[1:0];
        st_data = {2{lsu_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = lsu_wdata;
      end
    endcase
  end

  // Load lane selection and sign/zero extension from the latched request.
  always_comb begin
    lane = rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{(BIT_W-8){lane[7]}}, lane[7:0]};
      3'b100:  ld_ext = {{(BIT_W-8){1'b0}}, lane[7:0]};
      3'b001:  ld_ext = {{(BIT_W-16){lane[15]}}, lane[15:0]};
      3'b101:  ld_ext = {{(BIT_W-16){1'b0}}, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  // Per-state forward progress; a timeout only fires when no progress is made.
  always_comb begin
    aw_done  = !awvalid_o || awready;
    w_done   = !wvalid_o || wready;
    progress = 1'b0;
    case (state)
      RD_ADDR: progress = arready;
      RD_DATA: progress = rvalid;
      WR_REQ:  progress = aw_done && w_done;
      WR_RESP: progress = bvalid;
      default: progress = 1'b0;
    endcase
    tmo_fire = (state inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP})
               && !progress && (cnt == CNT_LAST);
  end

  // Transaction FSM with registered bus and EXU outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      is_load_q    <= 1'b0;
      lsu_rdata_o  <= '0;
      lsu_rvalid_o <= 1'b0;
      lsu_wready_o <= 1'b0;
      lsu_fault_o  <= 1'b0;
      araddr_o     <= '0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      awaddr_o     <= '0;
      awvalid_o    <= 1'b0;
      wdata_o      <= '0;
      wstrb_o      <= '0;
      wvalid_o     <= 1'b0;
      bready_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_avalid) begin
            off_q     <= lsu_addr[1:0];
            f3_q      <= lsu_func3;
            is_load_q <= lsu_ren;
            cnt       <= '0;
            if (lsu_ren == lsu_wen) begin
              state        <= DONE;
              lsu_rvalid_o <= 1'b1;
              lsu_wready_o <= 1'b1;
              lsu_fault_o  <= 1'b1;
            end else if (misal) begin
              state        <= DONE;
              lsu_rvalid_o <= lsu_ren;
              lsu_wready_o <= lsu_wen;
              lsu_fault_o  <= 1'b1;
              lsu_rdata_o  <= '0;
            end else if (lsu_ren) begin
              state     <= RD_ADDR;
              araddr_o  <= lsu_addr;
              arvalid_o <= 1'b1;
            end else begin
              state     <= WR_REQ;
              awaddr_o  <= lsu_addr;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              wdata_o   <= st_data;
              wstrb_o   <= st_strb;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= RD_DATA;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready_o     <= 1'b0;
            lsu_rdata_o  <= ld_ext;
            lsu_fault_o  <= (rresp != 2'b00);
            lsu_rvalid_o <= 1'b1;
            state        <= DONE;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_REQ: begin
          if (awready) awvalid_o <= 1'b0;
          if (wready)  wvalid_o  <= 1'b0;
          if (aw_done && w_done) begin
            bready_o <= 1'b1;
            state    <= WR_RESP;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_o     <= 1'b0;
            lsu_fault_o  <= (bresp != 2'b00);
            lsu_wready_o <= 1'b1;
            state        <= DONE;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          lsu_rvalid_o <= 1'b0;
          lsu_wready_o <= 1'b0;
          lsu_fault_o  <= 1'b0;
          state        <= IDLE;
          cnt          <= '0;
        end
        default: state <= IDLE;
      endcase
      // Timeout overrides whatever the busy state scheduled above.
      if (tmo_fire) begin
        arvalid_o    <= 1'b0;
        rready_o     <= 1'b0;
        awvalid_o    <= 1'b0;
        wvalid_o     <= 1'b0;
        bready_o     <= 1'b0;
        lsu_fault_o  <= 1'b1;
        lsu_rdata_o  <= '0;
        lsu_rvalid_o <= is_load_q;
        lsu_wready_o <= !is_load_q;
        state        <= DONE;
        cnt          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Testbench for ysyx_lsu: directed scenarios plus randomized requests
// against a behavioural model, with a configurable-latency bus slave.
module tb_ysyx_lsu;

  localparam int BIT_W   = 32;
  localparam int TIMEOUT = 255;

  logic        clk, rst;
  logic        lsu_avalid, lsu_ren, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [2:0]  lsu_func3;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rvalid_o, lsu_wready_o, lsu_fault_o;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o, awready;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready_o;

  int errors = 0;
  int checks = 0;

  // Slave configuration and observation
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic        ar_stall = 1'b0, r_stall = 1'b0;
  logic [31:0] rd_word = '0;
  logic [1:0]  rd_resp = '0, wr_resp = '0;
  int          ar_seen, aw_seen, aw_hs, w_hs;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [31:0] model_rd;

  ysyx_lsu #(.BIT_W(BIT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .lsu_avalid(lsu_avalid), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_func3(lsu_func3),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_wready_o(lsu_wready_o), .lsu_fault_o(lsu_fault_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready(awready),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready_o(bready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus slave: responds on the falling edge after a configurable wait.
  initial begin
    int ar_w, r_w, aw_w, w_w, b_w;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    ar_seen = 0; aw_seen = 0; aw_hs = 0; w_hs = 0;
    forever begin
      @(negedge clk);
      if (arvalid_o) begin
        ar_seen++;
        arready = !ar_stall && (ar_w >= ar_dly);
        if (arready) cap_araddr = araddr_o;
        ar_w++;
      end else begin arready = 0; ar_w = 0; end
      if (rready_o) begin
        rvalid = !r_stall && (r_w >= r_dly);
        rdata = rd_word; rresp = rd_resp;
        r_w++;
      end else begin rvalid = 0; r_w = 0; end
      if (awvalid_o) begin
        aw_seen++;
        awready = (aw_w >= aw_dly);
        if (awready) begin cap_awaddr = awaddr_o; aw_hs++; end
        aw_w++;
      end else begin awready = 0; aw_w = 0; end
      if (wvalid_o) begin
        wready = (w_w >= w_dly);
        if (wready) begin cap_wdata = wdata_o; cap_wstrb = wstrb_o; w_hs++; end
        w_w++;
      end else begin wready = 0; w_w = 0; end
      if (bready_o) begin
        bvalid = (b_w >= b_dly);
        bresp = wr_resp;
        b_w++;
      end else begin bvalid = 0; b_w = 0; end
    end
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit bad_req(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (sz == 0) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] f3);
    longint unsigned lane, span, v;
    int sz = size_of(f3);
    lane = word;
    lane = lane >> (8 * (a % 4));
    span = 64'd1 << (8 * sz);
    v = lane % span;
    if (f3 < 3'd4 && v >= span / 2) v = v + (64'd1 << 32) - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s = '0;
    int sz = size_of(f3);
    for (int i = 0; i < 4; i++)
      if (i >= (a % 4) && i < (a % 4) + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r = '0;
    logic [31:0] t;
    int sz = size_of(f3);
    for (int i = 0; i < 4; i++) begin
      t = d >> (8 * (i % sz));
      r[8*i +: 8] = t[7:0];
    end
    return r;
  endfunction

  // Issue one request and wait (bounded) for its completion pulse.
  task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int n, output logic rv, output logic wr,
                       output logic flt, output logic [31:0] rd, output logic arv);
    @(negedge clk);
    ar_seen = 0; aw_seen = 0; aw_hs = 0; w_hs = 0;
    lsu_avalid = 1; lsu_ren = ren; lsu_wen = wen; lsu_func3 = f3;
    lsu_addr = a; lsu_wdata = wd;
    n = 0; rv = 0; wr = 0;
    while (n < 400 && !rv && !wr) begin
      @(posedge clk); #1;
      n++;
      rv = lsu_rvalid_o; wr = lsu_wready_o;
    end
    flt = lsu_fault_o; rd = lsu_rdata_o; arv = arvalid_o;
    lsu_avalid = 0; lsu_ren = 0; lsu_wen = 0;
    checks++;
    if (!rv && !wr) begin
      errors++;
      $display("FAIL completion_wait: no pulse within %0d cycles, required a pulse", n);
    end
    @(posedge clk); #1;
    checks++;
    if ((lsu_rvalid_o | lsu_wready_o) !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: rvalid=%b wready=%b one cycle later, required 0 0",
               lsu_rvalid_o, lsu_wready_o);
    end
  endtask

  function automatic logic [222:0] all_outs();
    return {lsu_rdata_o, lsu_rvalid_o, lsu_wready_o, lsu_fault_o, araddr_o, arvalid_o,
            rready_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 0; lsu_avalid = 0; lsu_ren = 0; lsu_wen = 0;
    lsu_addr = '0; lsu_wdata = '0; lsu_func3 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs());
    end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_lw_basic();
    int n; logic rv, wr, flt, arv; logic [31:0] rd;
    rd_word = 32'hDEADBEEF; rd_resp = 0;
    issue(1, 0, 3'b010, 32'h80000004, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (n !== 3 || rv !== 1 || wr !== 0) begin
      errors++;
      $display("FAIL lw_latency: cycles=%0d rv=%b wr=%b, required 3 1 0", n, rv, wr);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || flt !== 0) begin
      errors++;
      $display("FAIL lw_data: rdata=%h fault=%b, required deadbeef 0", rd, flt);
    end
    checks++;
    if (cap_araddr !== 32'h80000004) begin
      errors++;
      $display("FAIL lw_araddr: got %h, required 80000004", cap_araddr);
    end
  endtask

  task automatic test_lb_variants();
    int n; logic rv, wr, flt, arv; logic [31:0] rd;
    rd_word = 32'h80123456;
    issue(1, 0, 3'b000, 32'h80000003, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (rd !== 32'hFFFFFF80 || flt !== 0) begin
      errors++; $display("FAIL lb_sign: rdata=%h fault=%b, required ffffff80 0", rd, flt);
    end
    issue(1, 0, 3'b100, 32'h80000003, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++; $display("FAIL lbu_zero: rdata=%h, required 00000080", rd);
    end
    issue(1, 0, 3'b101, 32'h80000002, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (rd !== 32'h00008012) begin
      errors++; $display("FAIL lhu_zero: rdata=%h, required 00008012", rd);
    end
    issue(1, 0, 3'b001, 32'h80000002, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (rd !== 32'hFFFF8012) begin
      errors++; $display("FAIL lh_sign: rdata=%h, required ffff8012", rd);
    end
  endtask

  task automatic test_sh_delayed();
    int n; logic rv, wr, flt, arv; logic [31:0] rd;
    aw_dly = 3; w_dly = 0; b_dly = 0; wr_resp = 0;
    issue(0, 1, 3'b001, 32'h80000002, 32'h1234ABCD, n, rv, wr, flt, rd, arv);
    checks++;
    if (wr !== 1 || rv !== 0 || flt !== 0) begin
      errors++; $display("FAIL sh_done: wr=%b rv=%b fault=%b, required 1 0 0", wr, rv, flt);
    end
    checks++;
    if (cap_wstrb !== 4'b1100 || cap_wdata !== 32'hABCDABCD || cap_awaddr !== 32'h80000002) begin
      errors++;
      $display("FAIL sh_bus: strb=%b wdata=%h awaddr=%h, required 1100 abcdabcd 80000002",
               cap_wstrb, cap_wdata, cap_awaddr);
    end
    checks++;
    if (aw_seen !== 4 || aw_hs !== 1 || w_hs !== 1) begin
      errors++;
      $display("FAIL sh_awvalid_hold: aw_cycles=%0d aw_hs=%0d w_hs=%0d, required 4 1 1",
               aw_seen, aw_hs, w_hs);
    end
    aw_dly = 0;
  endtask

  task automatic test_misaligned();
    int n; logic rv, wr, flt, arv; logic [31:0] rd;
    issue(1, 0, 3'b010, 32'h80000001, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (n !== 1 || rv !== 1 || flt !== 1 || rd !== 0 || ar_seen !== 0) begin
      errors++;
      $display("FAIL lw_misaligned: cycles=%0d rv=%b fault=%b rdata=%h ar_cycles=%0d, required 1 1 1 0 0",
               n, rv, flt, rd, ar_seen);
    end
  endtask

  task automatic test_both_enable();
    int n; logic rv, wr, flt, arv; logic [31:0] rd;
    issue(1, 1, 3'b010, 32'h80000000, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (rv !== 1 || wr !== 1 || flt !== 1 || ar_seen !== 0 || aw_seen !== 0) begin
      errors++;
      $display("FAIL both_enable: rv=%b wr=%b fault=%b ar=%0d aw=%0d, required 1 1 1 0 0",
               rv, wr, flt, ar_seen, aw_seen);
    end
  endtask

  task automatic test_rresp_err();
    int n; logic rv, wr, flt, arv; logic [31:0] rd;
    rd_word = 32'h11223344; rd_resp = 2'b10;
    issue(1, 0, 3'b010, 32'h80000008, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (rv !== 1 || flt !== 1) begin
      errors++; $display("FAIL rresp_fault: rv=%b fault=%b, required 1 1", rv, flt);
    end
    rd_resp = 0;
  endtask

  task automatic test_timeout();
    int n; logic rv, wr, flt, arv; logic [31:0] rd;
    ar_stall = 1;
    issue(1, 0, 3'b010, 32'h80000010, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (n < TIMEOUT || n > TIMEOUT + 2 || rv !== 1 || flt !== 1 || rd !== 0 || arv !== 0) begin
      errors++;
      $display("FAIL ar_timeout: cycles=%0d rv=%b fault=%b rdata=%h arvalid=%b, required %0d..%0d 1 1 0 0",
               n, rv, flt, rd, arv, TIMEOUT, TIMEOUT + 2);
    end
    ar_stall = 0;
  endtask

  task automatic test_reset_mid();
    int n, k; logic rv, wr, flt, arv; logic [31:0] rd;
    r_stall = 1;
    @(negedge clk);
    lsu_avalid = 1; lsu_ren = 1; lsu_wen = 0; lsu_func3 = 3'b010; lsu_addr = 32'h80000020;
    k = 0;
    while (!rready_o && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (rready_o !== 1) begin
      errors++; $display("FAIL reach_rd_data: rready=%b after %0d cycles, required 1", rready_o, k);
    end
    rst = 0;
    @(posedge clk); #1;
    lsu_avalid = 0; lsu_ren = 0;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h, required 0", all_outs());
    end
    @(negedge clk); rst = 1; r_stall = 0;
    rd_word = 32'hCAFEF00D;
    issue(1, 0, 3'b010, 32'h80000024, '0, n, rv, wr, flt, rd, arv);
    checks++;
    if (n !== 3 || rv !== 1 || flt !== 0 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lw_after_reset: cycles=%0d rv=%b fault=%b rdata=%h, required 3 1 0 cafef00d",
               n, rv, flt, rd);
    end
    model_rd = 32'hCAFEF00D;
  endtask

  task automatic test_random();
    int n, sel, sz; logic rv, wr, flt, arv; logic [31:0] rd;
    logic ren, wen; logic [2:0] f3; logic [31:0] a, d, e;
    logic [2:0] ld_f3 [10];
    logic [2:0] st_f3 [7];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd4, 3'd3, 3'd6};
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd7};
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 11);
      ren = (sel == 0) || (sel >= 2 && sel <= 6);
      wen = (sel == 0) || (sel >= 7);
      f3 = ren ? ld_f3[$urandom_range(0, 9)] : st_f3[$urandom_range(0, 6)];
      a = $urandom; d = $urandom;
      sz = size_of(f3);
      if (sz != 0 && $urandom_range(0, 3) != 0) a = a - (a % sz);
      rd_word = $urandom;
      rd_resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      wr_resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      issue(ren, wen, f3, a, d, n, rv, wr, flt, rd, arv);
      checks++;
      if (ren == wen) begin
        if (rv !== 1 || wr !== 1 || flt !== 1 || rd !== model_rd || ar_seen !== 0 || aw_seen !== 0) begin
          errors++;
          $display("FAIL rand_kind it=%0d: rv=%b wr=%b fault=%b rdata=%h, required 1 1 1 %h", it, rv, wr, flt, rd, model_rd);
        end
      end else if (bad_req(f3, a)) begin
        model_rd = '0;
        if (rv !== ren || wr !== wen || flt !== 1 || rd !== 0 || ar_seen !== 0 || aw_seen !== 0) begin
          errors++;
          $display("FAIL rand_misal it=%0d f3=%0d a=%h: rv=%b wr=%b fault=%b rdata=%h, required %b %b 1 0",
                   it, f3, a, rv, wr, flt, rd, ren, wen);
        end
      end else if (ren) begin
        e = exp_load(rd_word, a, f3);
        model_rd = e;
        if (rv !== 1 || wr !== 0 || rd !== e || flt !== (rd_resp != 0) || cap_araddr !== a) begin
          errors++;
          $display("FAIL rand_load it=%0d f3=%0d a=%h word=%h: rdata=%h fault=%b araddr=%h, required %h %b %h",
                   it, f3, a, rd_word, rd, flt, cap_araddr, e, rd_resp != 0, a);
        end
      end else begin
        if (wr !== 1 || rv !== 0 || flt !== (wr_resp != 0) || rd !== model_rd ||
            cap_wstrb !== exp_strb(f3, a) || cap_wdata !== exp_wdata(f3, d) || cap_awaddr !== a) begin
          errors++;
          $display("FAIL rand_store it=%0d f3=%0d a=%h: strb=%b wdata=%h fault=%b rdata=%h, required %b %h %b %h",
                   it, f3, a, cap_wstrb, cap_wdata, flt, rd, exp_strb(f3, a), exp_wdata(f3, d),
                   wr_resp != 0, model_rd);
        end
      end
    end
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; rd_resp = 0; wr_resp = 0;
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_lb_variants();
    test_sh_delayed();
    test_misaligned();
    test_both_enable();
    test_rresp_err();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
